// File: rtl/count_game_pkg.sv
// count_game_pkg
//   Shared definitions for the count-game keypad path: scanner state
//   encoding, keypad geometry and the key codes the game logic decodes.
//   Key code = row*4 + col.
package count_game_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    DEBOUNCE = 3'd2,
    PRESSED  = 3'd3,
    RELEASE  = 3'd4
  } scan_state_e;

  // Digits sit on rows 0-1; the control keys sit on row 3.
  localparam logic [3:0] KEY_0     = 4'd0;
  localparam logic [3:0] KEY_1     = 4'd1;
  localparam logic [3:0] KEY_2     = 4'd2;
  localparam logic [3:0] KEY_3     = 4'd3;
  localparam logic [3:0] KEY_4     = 4'd4;
  localparam logic [3:0] KEY_5     = 4'd5;
  localparam logic [3:0] KEY_6     = 4'd6;
  localparam logic [3:0] KEY_7     = 4'd7;
  localparam logic [3:0] KEY_START = 4'd14;
  localparam logic [3:0] KEY_CLR   = 4'd15;

  // Index of the low column in an active-low pattern. Only meaningful when
  // exactly one bit is low.
  function automatic logic [1:0] low_col_idx(input logic [COLS-1:0] col_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!col_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_sync.sv
// key_sync
//   Two-flop synchroniser for asynchronous, pulled-up (idle-high) inputs.
//   Resets to all-ones so a reset reads as "nothing pressed".
// Ports:
//   clk  : sampling clock
//   rst  : asynchronous active-high reset
//   d_i  : asynchronous input bus
//   q_o  : synchronised output bus, two clocks of latency
module key_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
//   4x4 active-low matrix keypad scanner. Walks the rows, samples the
//   synchronised column returns, debounces press and release, and emits one
//   key_valid pulse per physical press.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   en         : scan enable, low parks the scanner with rows released
//   key_col_n  : column returns, active-low, asynchronous
//   key_row_n  : row drive, one-hot-low while active
//   key_code   : last accepted key, row*4 + col
//   key_valid  : one-clock pulse on acceptance
//   key_held   : high from acceptance until release is debounced
//
// state    | meaning
// IDLE     | rows released, waiting for en
// SCAN     | driving one row, dwell timer running before column sample
// DEBOUNCE | single key seen, row frozen, counting stable clocks
// PRESSED  | key accepted, waiting for all columns high
// RELEASE  | all columns high, counting stable clocks before re-scan
module keypad_scan
  import count_game_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CYC = 20,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] key_col_n,
  output logic [3:0] key_row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [3:0]       col_s;
  scan_state_e      state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [3:0]       pat_q, pat_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             one_low;
  logic             all_high;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  key_sync #(.W(COLS)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d_i (key_col_n),
    .q_o (col_s)
  );

  // Two or more low columns is a ghost or multi-press and is treated like
  // no key at all.
  assign one_low  = ($countones(~col_s) == 1);
  assign all_high = (col_s == 4'hF);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    deb_d   = deb_q;
    pat_d   = pat_q;
    col_d   = col_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SCAN;
          row_d   = 2'd0;
          dwell_d = '0;
        end
      end
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          if (one_low) begin
            pat_d   = col_s;
            col_d   = low_col_idx(col_s);
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            row_d   = row_q + 2'd1;
            dwell_d = '0;
          end
        end else begin
          dwell_d = sat_inc(dwell_q);
        end
      end
      DEBOUNCE: begin
        if (col_s != pat_q) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          dwell_d = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          code_d  = {row_q, col_q};
          valid_d = 1'b1;
          held_d  = 1'b1;
        end else begin
          deb_d = sat_inc(deb_q);
        end
      end
      PRESSED: begin
        if (all_high) begin
          state_d = RELEASE;
          deb_d   = '0;
        end
      end
      RELEASE: begin
        if (!all_high) begin
          state_d = PRESSED;
        end else if (deb_q == DEB_LAST) begin
          held_d  = 1'b0;
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          dwell_d = '0;
        end else begin
          deb_d = sat_inc(deb_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable wins over every transition, but an acceptance in the same
    // cycle still delivers its pulse and code.
    if (!en) begin
      state_d = IDLE;
      held_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
      dwell_q <= '0;
      deb_q   <= '0;
      pat_q   <= 4'hF;
      col_q   <= 2'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      dwell_q <= dwell_d;
      deb_q   <= deb_d;
      pat_q   <= pat_d;
      col_q   <= col_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    key_row_n = 4'hF;
    if (state_q != IDLE) key_row_n = ~(4'b0001 << row_q);
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] key_col_n;
  logic [3:0] key_row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       press_on;
  logic       ghost_on;
  logic [1:0] press_r;
  logic [1:0] press_c;

  int         checks = 0;
  int         errors = 0;
  int         vcount = 0;
  logic [3:0] vcode  = 4'd0;
  logic [3:0] rows_seen = 4'd0;

  always #5 clk = ~clk;

  // Keypad model: a pressed key shorts its row to its column.
  always_comb begin
    key_col_n = 4'hF;
    if (ghost_on && !key_row_n[0]) key_col_n = 4'b1001;
    else if (press_on && !key_row_n[press_r]) key_col_n = ~(4'b0001 << press_c);
  end

  keypad_scan #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .key_col_n (key_col_n),
    .key_row_n (key_row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  task automatic tick();
    @(negedge clk);
    if (key_valid) begin
      vcount++;
      vcode = key_code;
    end
    rows_seen |= ~key_row_n;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_held(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (key_held !== lvl && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(key_held), 32'(lvl));
  endtask

  initial begin
    int stable;
    int n;

    rst = 1'b1; en = 1'b0;
    press_on = 1'b0; ghost_on = 1'b0; press_r = 2'd0; press_c = 2'd0;
    ticks(2);
    check("rst_rows",  32'(key_row_n), 32'hF);
    check("rst_code",  32'(key_code),  32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held",  32'(key_held),  32'h0);

    rst = 1'b0;
    tick();
    check("idle_rows", 32'(key_row_n), 32'hF);
    en = 1'b1;
    tick();
    check("scan_row0", 32'(key_row_n), 32'hE);
    ticks(4);
    check("scan_row1", 32'(key_row_n), 32'hD);

    // Clean press of row 2 col 1.
    vcount = 0;
    press_r = 2'd2; press_c = 2'd1; press_on = 1'b1;
    ticks(40);
    check("clean_vcount", 32'(vcount),    32'd1);
    check("clean_vcode",  32'(vcode),     32'd9);
    check("clean_code",   32'(key_code),  32'd9);
    check("clean_held",   32'(key_held),  32'd1);
    check("clean_frozen", 32'(key_row_n), 32'hB);
    press_on = 1'b0;
    ticks(10);
    check("clean_rel_hold", 32'(key_held), 32'd1);
    tick();
    check("clean_rel_drop", 32'(key_held),  32'd0);
    check("clean_row3",     32'(key_row_n), 32'h7);
    ticks(4);
    check("clean_row0",     32'(key_row_n), 32'hE);
    check("clean_one_evt",  32'(vcount),    32'd1);

    // Bouncing contact never stays stable long enough.
    vcount = 0;
    press_r = 2'd3; press_c = 2'd1;
    repeat (3) begin
      press_on = 1'b1; ticks(5);
      press_on = 1'b0; ticks(1);
      press_on = 1'b1; ticks(5);
      press_on = 1'b0; ticks(1);
    end
    ticks(4);
    check("bounce_vcount", 32'(vcount),   32'd0);
    check("bounce_held",   32'(key_held), 32'd0);
    rows_seen = 4'd0;
    ticks(20);
    check("bounce_rows", 32'(rows_seen), 32'hF);

    // Ghost pattern on row 0.
    vcount = 0;
    rows_seen = 4'd0;
    ghost_on = 1'b1;
    ticks(30);
    check("ghost_vcount", 32'(vcount),    32'd0);
    check("ghost_held",   32'(key_held),  32'd0);
    check("ghost_rows",   32'(rows_seen), 32'hF);
    ghost_on = 1'b0;

    // Key 5 with a bouncy release.
    vcount = 0;
    press_r = 2'd1; press_c = 2'd1; press_on = 1'b1;
    wait_held(1'b1, 60, "k5_held");
    ticks(5);
    check("k5_vcount", 32'(vcount), 32'd1);
    check("k5_vcode",  32'(vcode),  32'd5);
    press_on = 1'b0; ticks(4);
    press_on = 1'b1; ticks(2);
    press_on = 1'b0; ticks(10);
    check("k5_rel_hold", 32'(key_held), 32'd1);
    tick();
    check("k5_rel_drop", 32'(key_held), 32'd0);
    check("k5_one_evt",  32'(vcount),   32'd1);

    // Asynchronous reset while a key is held.
    vcount = 0;
    press_r = 2'd3; press_c = 2'd2; press_on = 1'b1;
    wait_held(1'b1, 60, "k14_held");
    ticks(3);
    check("k14_vcount", 32'(vcount), 32'd1);
    check("k14_vcode",  32'(vcode),  32'd14);
    rst = 1'b1;
    #1;
    check("arst_rows",  32'(key_row_n), 32'hF);
    check("arst_held",  32'(key_held),  32'd0);
    check("arst_code",  32'(key_code),  32'd0);
    check("arst_valid", 32'(key_valid), 32'd0);
    ticks(2);
    rst = 1'b0;
    vcount = 0;
    wait_held(1'b1, 80, "post_rst_held");
    ticks(3);
    check("post_rst_vcount", 32'(vcount), 32'd1);
    check("post_rst_vcode",  32'(vcode),  32'd14);
    press_on = 1'b0;
    wait_held(1'b0, 40, "post_rst_release");

    // Drop en while debouncing key 3.
    vcount = 0;
    press_r = 2'd0; press_c = 2'd3; press_on = 1'b1;
    stable = 0;
    n = 0;
    while (stable < 6 && n < 80) begin
      tick();
      n++;
      if (key_row_n == 4'hE) stable++;
      else stable = 0;
    end
    check("en_deb_reached", 32'(stable), 32'd6);
    en = 1'b0;
    tick();
    check("en_rows_off", 32'(key_row_n), 32'hF);
    check("en_held",     32'(key_held),  32'd0);
    ticks(10);
    check("en_vcount",   32'(vcount),    32'd0);
    check("en_code_kept", 32'(key_code), 32'd14);
    press_on = 1'b0;
    en = 1'b1;
    tick();
    check("en_restart_row0", 32'(key_row_n), 32'hE);
    ticks(4);
    check("en_restart_row1", 32'(key_row_n), 32'hD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Matrix keypad scanner for the count game. It is the input-side counterpart of the dot-matrix display path: it drives rows and reads columns instead of driving rows and columns out.
- Scans a 4x4 active-low keypad, synchronises and debounces the column returns, and emits one key event per physical press.
- Downstream game logic uses the events to load the countdown preset and to issue start.

Parameters:
- SCAN_DIV, 4: clocks each row is driven before its columns are sampled. Legal minimum is 3, to cover synchroniser settling.
- DEBOUNCE_CYC, 20: consecutive stable clocks required to accept a press or a release. At the 1 kHz game clock this is 20 ms.
- CNT_W, 8: width of the dwell and debounce counters. Must hold max(SCAN_DIV, DEBOUNCE_CYC).

Ports:
- clk  input  1  system clock (1 kHz in the game build).
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  scan enable. Low parks the scanner.
- key_col_n  input  4  column returns, active-low, externally pulled up, asynchronous to clk.
- key_row_n  output  4  row drive, active-low, one-hot-low while scanning.
- key_code  output  4  code of the last accepted key = row*4 + col.
- key_valid  output  1  one-clock pulse when a new key is accepted.
- key_held  output  1  high from acceptance until release is debounced.

Behaviour:
- Reset values: key_row_n=4'b1111, key_code=0, key_valid=0, key_held=0, row index=0, state=IDLE, all counters 0.
- key_col_n passes through a 2-flop synchroniser. All logic uses the synchronised value col_s.
- States and transitions:
  - IDLE: rows 1111. If en=1, go to SCAN with row 0 driven (1110) and the dwell counter cleared.
  - SCAN:
    - The dwell counter counts 0..SCAN_DIV-1.
    - On the dwell==SCAN_DIV-1 cycle, col_s is sampled:
      - Exactly one bit low: capture the pattern and column index, freeze the row, clear the debounce counter, go to DEBOUNCE.
      - All high, or two or more bits low (ghost/multi-press, ignored): advance the row index mod 4 (3 wraps to 0) and clear dwell.
  - DEBOUNCE:
    - Each clock col_s equals the captured pattern: the counter increments.
    - Any mismatch: go to SCAN at the next row, no event.
    - Counter reaches DEBOUNCE_CYC-1 with a match: go to PRESSED. On that transition key_code=row*4+col and key_valid=1 for exactly one clock; key_held=1 from the same clock.
    - Latency: the pulse lands DEBOUNCE_CYC clocks after the capture sample when the input is stable.
  - PRESSED: row stays frozen. col_s all high: go to RELEASE with the counter cleared. A change to a different low pattern is ignored; wait for all-high.
  - RELEASE:
    - col_s all high: the counter increments.
    - Any low bit: go back to PRESSED, no new key_valid.
    - Counter reaches DEBOUNCE_CYC-1: key_held=0, go to SCAN at the next row.
- en=0 in any state: next clock goes to IDLE, rows 1111, key_held=0. key_code is kept. A key_valid pulse already asserted is not extended.
- key_valid and the en=0 transition in the same cycle: the pulse is still delivered and key_code is updated.
- Asynchronous rst mid-press: all outputs return to reset values immediately, with no event on reset exit. A key still down after reset is detected fresh through SCAN/DEBOUNCE.
- Exactly one key_valid per press. Holding a key never repeats.
- Counter widths are CNT_W. Counters saturate and never wrap.

Decomposition:
- Shared package count_game_pkg:
  - scan state enum (IDLE, SCAN, DEBOUNCE, PRESSED, RELEASE);
  - key code constants (KEY_0..KEY_7 digit codes, KEY_START, KEY_CLR);
  - ROWS=4 and COLS=4 constants.
- One sub-module, key_sync: a parameter-width 2-flop synchroniser with async reset to all-ones. This is the natural split; everything else stays in keypad_scan.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_CYC=8):
- Clean press: hold row 2 col 1 low (key_col_n=1101 while key_row_n=1011) for 40 clocks, then release. Required response: one key_valid pulse with key_code=9, key_held high until 8 clocks of release, rows resume 0111 then 1110.
- Bounce on press: toggle col 1 low for 5 clocks, high 1, low 5. Required response: no key_valid, scanning continues across all 4 rows.
- Ghost press: col pattern 1001 on row 0 for 30 clocks. Required response: no key_valid, key_held=0, row index keeps cycling.
- Release bounce: press key 5 (row 1, col 1), then during release go high 4 clocks, low 2, high 10. Required response: a single key_valid (code 5), key_held drops only after the final 8 high clocks.
- Reset in PRESSED: assert rst while key_held=1. Required response: key_row_n=1111, key_held=0, key_code=0 immediately. With the key still held after rst drops, exactly one new key_valid occurs.
- en drop: deassert en during DEBOUNCE. Required response: next clock rows=1111, no key_valid. Re-assert en: scan restarts at row 0.
